branch_resolver: RTL and testbench
==================================

# branch_resolver

Downstream consumer of the 16-bit compare stage: samples the `LT`/`Equal` flags alongside a decoded branch operation and target, decides taken/not-taken, and drives a registered PC redirect to fetch with a request/acknowledge handshake. After the redirect is accepted, it holds a pipeline flush for a fixed number of cycles. It sits between execute (compare) and the fetch/PC-select logic.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `Flush` is held after a redirect is acknowledged. Legal range 0..7.
- `ADDR_W`, default 16: PC/target width.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `Reset_n`, in, 1: synchronous, active-low reset.
- `Valid`, in, 1: branch operation present this cycle.
- `Ready`, out, 1: block can accept an operation.
- `Op`, in, 3: branch operation code (encodings in package).
- `LT`, in, 1: A<B flag from the comparator.
- `Equal`, in, 1: A==B flag from the comparator.
- `Target`, in, ADDR_W: branch destination.
- `Redirect`, out, 1: redirect request to fetch.
- `RedirectPC`, out, ADDR_W: new PC; valid while `Redirect`=1.
- `RedirectAck`, in, 1: fetch accepts the redirect.
- `Flush`, out, 1: squash younger instructions.
- `Taken`, out, 1: one-cycle pulse, registered, for each accepted operation that resolves taken.

## Operation
- Op encodings: NOP=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLE=5, BGT=6, JMP=7.
- Conditions:
  - EQ = `Equal`; NE = !`Equal`.
  - LT = `LT` & !`Equal`; GE = !LT.
  - LE = `LT` | `Equal`; GT = !LE.
  - JMP is always taken; NOP is never taken.
  - `LT`=1 with `Equal`=1 is an illegal input. `Equal` wins: BLT resolves not-taken and BLE resolves taken.
- Accept = `Valid` & `Ready`. `Valid` while `Ready`=0 is ignored and not queued.
- FSM states:
  - IDLE (`Ready`=1). Accept and taken: latch `Target` into `RedirectPC`, go to REQ. Accept and not-taken: stay in IDLE.
  - REQ (`Redirect`=1, `Ready`=0). Hold `RedirectPC` stable. When `RedirectAck`=1: go to FLUSH if `FLUSH_CYCLES`>0, otherwise go to IDLE.
  - FLUSH (`Flush`=1, `Ready`=0). A down-counter loaded with `FLUSH_CYCLES` on the ack. Decrement each cycle; go to IDLE when the count reaches 1.
- `RedirectAck` outside REQ is ignored.
- Reset values: state IDLE, `Ready`=1, `Redirect`=0, `RedirectPC`=0, `Flush`=0, `Taken`=0, counter 0.
- Reset asserted in any state, including mid-REQ or mid-FLUSH, abandons the operation on the next edge. No redirect or flush persists after reset.

## Timing
- Flags and `Op` are sampled on the accept edge. The taken decision is combinational from the inputs and registered on that edge.
- `Redirect` and `Taken` rise 1 cycle after accept.
- Earliest ack is the first cycle `Redirect`=1. `Redirect` drops on the edge that samples the ack.
- `Flush` is high for exactly `FLUSH_CYCLES` cycles, starting the cycle after the ack edge.
- `Ready` returns high the cycle after the last `Flush` cycle.
- Minimum taken-branch occupancy is 2+`FLUSH_CYCLES` cycles.
- Not-taken branches have throughput 1 per cycle.

## Configuration
- `BRANCH_RESOLVER_STATS_EN`
  - Defined: adds two 16-bit saturating counters, `TakenCount` and `NotTakenCount` (outputs, ADDR_W-independent). They increment on each accepted non-NOP op by outcome, saturate at 16'hFFFF, and reset to 0.
  - Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `branch_pkg` holds:
  - Op encodings;
  - FSM state encodings (IDLE=0, REQ=1, FLUSH=2);
  - the `FLUSH_CYCLES` legal maximum.
- One sub-module, `branch_cond`: purely combinational `Op`/`LT`/`Equal` to taken decode, reused by the verification model.
- The FSM, counter and registers stay in the top level.

## Test plan
- Reset and not-taken:
  - Hold `Reset_n`=0 for 2 cycles: all outputs at their reset values.
  - Release, then BEQ with `Equal`=0: `Redirect` stays 0, `Ready` stays 1, `Taken` stays 0.
- BLT taken, delayed ack:
  - BLT, `LT`=1, `Equal`=0, `Target`=16'h0040, with ack held off 3 cycles: `Redirect`=1 and `RedirectPC`=16'h0040 from cycle+1 through the ack.
  - `Flush`=1 for exactly 2 cycles, then `Ready`=1.
- Immediate ack, `FLUSH_CYCLES`=0:
  - JMP to 16'hFFFE, ack in the first `Redirect` cycle: `Redirect` is high 1 cycle, `Flush` never asserts, `Ready`=1 two cycles after accept.
- Illegal flags and back-to-back:
  - `LT`=1, `Equal`=1: BLT not-taken, BLE taken, BGT not-taken.
  - `Valid` pulsed every cycle during REQ/FLUSH: all ignored, no second redirect.
- Reset mid-operation:
  - `Reset_n`=0 during FLUSH with count 1: next cycle `Flush`=0, `Ready`=1, IDLE.
  - Reset during REQ: `Redirect`=0 next cycle.
- Statistics (`BRANCH_RESOLVER_STATS_EN` defined):
  - 3 taken, 5 not-taken, 2 NOP: `TakenCount`=3, `NotTakenCount`=5.
  - Preset to 16'hFFFF: the count holds at 16'hFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolver: op codes, FSM states, flush bound.
package branch_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_BEQ = 3'd1,
        OP_BNE = 3'd2,
        OP_BLT = 3'd3,
        OP_BGE = 3'd4,
        OP_BLE = 3'd5,
        OP_BGT = 3'd6,
        OP_JMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int FLUSH_MAX = 7;
    localparam int CNT_W     = 3;

endpackage

// File: rtl/branch_cond.sv
// Combinational op/flag decode to taken. Equal overrides LT when both are set,
// so the illegal LT&Equal input behaves as "equal".
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] op,
    input  logic       lt,
    input  logic       equal,
    output logic       taken
);

    logic lt_strict;
    logic le;

    assign lt_strict = lt & ~equal;
    assign le        = lt | equal;

    always_comb begin
        taken = 1'b0;
        case (op_e'(op))
            OP_NOP: taken = 1'b0;
            OP_BEQ: taken = equal;
            OP_BNE: taken = ~equal;
            OP_BLT: taken = lt_strict;
            OP_BGE: taken = ~lt_strict;
            OP_BLE: taken = le;
            OP_BGT: taken = ~le;
            OP_JMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branches, issues a held PC redirect until acked, then flushes for FLUSH_CYCLES.
// BRANCH_RESOLVER_STATS_EN adds saturating TakenCount/NotTakenCount outputs.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 16
)
(
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Valid,
    output logic              Ready,
    input  logic [2:0]        Op,
    input  logic              LT,
    input  logic              Equal,
    input  logic [ADDR_W-1:0] Target,
    output logic              Redirect,
    output logic [ADDR_W-1:0] RedirectPC,
    input  logic              RedirectAck,
    output logic              Flush,
    output logic              Taken
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]       TakenCount,
    output logic [15:0]       NotTakenCount
`endif
);

    localparam logic             HAS_FLUSH  = (FLUSH_CYCLES > 0);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cond_taken;
    logic              accept;

    branch_cond u_cond (
        .op    (Op),
        .lt    (LT),
        .equal (Equal),
        .taken (cond_taken)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Ready    = 1'b0;
        Redirect = 1'b0;
        Flush    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                Ready  = 1'b1;
                accept = Valid;
                if (Valid && cond_taken) state_d = ST_REQ;
            end
            ST_REQ: begin
                Redirect = 1'b1;
                if (RedirectAck) begin
                    if (HAS_FLUSH) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                Flush = 1'b1;
                // Leaving on count 1 gives exactly FLUSH_CYCLES flush cycles.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            RedirectPC <= '0;
            Taken      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            Taken   <= accept & cond_taken;
            if (accept && cond_taken) RedirectPC <= Target;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic counted;
    assign counted = accept && (op_e'(Op) != OP_NOP);

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            TakenCount    <= '0;
            NotTakenCount <= '0;
        end else if (counted) begin
            if (cond_taken) begin
                if (TakenCount != 16'hFFFF) TakenCount <= TakenCount + 16'd1;
            end else begin
                if (NotTakenCount != 16'hFFFF) NotTakenCount <= NotTakenCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: default instance (FLUSH_CYCLES=2) and a FLUSH_CYCLES=0 instance.
module tb_branch_resolver;
    import branch_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        Valid, LT, Equal, RedirectAck;
    logic [2:0]  Op;
    logic [15:0] Target;
    logic        Ready, Redirect, Flush, Taken;
    logic [15:0] RedirectPC;

    logic        v1, ack1;
    logic [2:0]  op1;
    logic [15:0] tgt1;
    logic        rdy1, redir1, flush1, taken1;
    logic [15:0] pc1;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] TakenCount, NotTakenCount, tc1, ntc1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    branch_resolver #(.FLUSH_CYCLES(2), .ADDR_W(16)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Valid(Valid), .Ready(Ready), .Op(Op),
        .LT(LT), .Equal(Equal), .Target(Target), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .RedirectAck(RedirectAck), .Flush(Flush), .Taken(Taken)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .TakenCount(TakenCount), .NotTakenCount(NotTakenCount)
`endif
    );

    branch_resolver #(.FLUSH_CYCLES(0), .ADDR_W(16)) dut0 (
        .CLK(CLK), .Reset_n(Reset_n), .Valid(v1), .Ready(rdy1), .Op(op1),
        .LT(1'b0), .Equal(1'b0), .Target(tgt1), .Redirect(redir1),
        .RedirectPC(pc1), .RedirectAck(ack1), .Flush(flush1), .Taken(taken1)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .TakenCount(tc1), .NotTakenCount(ntc1)
`endif
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic l, input logic e, input logic [15:0] t);
        Valid = v; Op = o; LT = l; Equal = e; Target = t;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        RedirectAck = 1'b0; v1 = 1'b0; op1 = OP_NOP; tgt1 = 16'h0; ack1 = 1'b0;
        step(); step();
        checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", Ready); end
        checks++; if ({Redirect, Flush, Taken} !== 3'b000) begin errors++; $display("FAIL reset_outs got %b want 000", {Redirect, Flush, Taken}); end
        checks++; if (RedirectPC !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", RedirectPC); end
        checks++; if ({rdy1, redir1, flush1, taken1} !== 4'b1000) begin errors++; $display("FAIL reset_dut0 got %b want 1000", {rdy1, redir1, flush1, taken1}); end
`ifdef BRANCH_RESOLVER_STATS_EN
        checks++; if ({TakenCount, NotTakenCount} !== 32'h0) begin errors++; $display("FAIL reset_stats got %h want 0", {TakenCount, NotTakenCount}); end
`endif
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_not_taken();
        drive(1'b1, OP_BEQ, 1'b0, 1'b0, 16'h1111);
        step();
        drive(1'b1, OP_BNE, 1'b0, 1'b1, 16'h2222);
        checks++; if ({Ready, Redirect, Taken} !== 3'b100) begin errors++; $display("FAIL beq_nt got %b want 100", {Ready, Redirect, Taken}); end
        step();
        drive(1'b1, OP_BGE, 1'b1, 1'b0, 16'h3333);
        checks++; if ({Ready, Redirect, Taken} !== 3'b100) begin errors++; $display("FAIL bne_nt got %b want 100", {Ready, Redirect, Taken}); end
        step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if ({Ready, Redirect, Taken} !== 3'b100) begin errors++; $display("FAIL bge_nt got %b want 100", {Ready, Redirect, Taken}); end
        step();
    endtask

    task automatic test_blt_delayed_ack();
        drive(1'b1, OP_BLT, 1'b1, 1'b0, 16'h0040);
        step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if ({Ready, Redirect, Taken} !== 3'b011) begin errors++; $display("FAIL blt_accept got %b want 011", {Ready, Redirect, Taken}); end
        checks++; if (RedirectPC !== 16'h0040) begin errors++; $display("FAIL blt_pc got %h want 0040", RedirectPC); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({Redirect, Taken, Flush} !== 3'b100 || RedirectPC !== 16'h0040) begin
                errors++; $display("FAIL blt_hold%0d got %b/%h want 100/0040", i, {Redirect, Taken, Flush}, RedirectPC); end
        end
        RedirectAck = 1'b1;
        step();
        RedirectAck = 1'b0;
        checks++; if ({Redirect, Flush, Ready} !== 3'b010) begin errors++; $display("FAIL blt_flush1 got %b want 010", {Redirect, Flush, Ready}); end
        step();
        checks++; if ({Redirect, Flush, Ready} !== 3'b010) begin errors++; $display("FAIL blt_flush2 got %b want 010", {Redirect, Flush, Ready}); end
        step();
        checks++; if ({Redirect, Flush, Ready} !== 3'b001) begin errors++; $display("FAIL blt_ready got %b want 001", {Redirect, Flush, Ready}); end
    endtask

    task automatic test_immediate_ack_no_flush();
        v1 = 1'b1; op1 = OP_JMP; tgt1 = 16'hFFFE;
        step();
        v1 = 1'b0;
        checks++; if ({redir1, taken1, rdy1} !== 3'b110 || pc1 !== 16'hFFFE) begin
            errors++; $display("FAIL jmp_req got %b/%h want 110/fffe", {redir1, taken1, rdy1}, pc1); end
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        checks++; if ({redir1, flush1, rdy1} !== 3'b001) begin errors++; $display("FAIL jmp_done got %b want 001", {redir1, flush1, rdy1}); end
        step();
        checks++; if ({redir1, flush1, rdy1} !== 3'b001) begin errors++; $display("FAIL jmp_idle got %b want 001", {redir1, flush1, rdy1}); end
    endtask

    task automatic test_illegal_flags_back_to_back();
        drive(1'b1, OP_BLT, 1'b1, 1'b1, 16'h0100);
        step();
        drive(1'b1, OP_BGT, 1'b1, 1'b1, 16'h0200);
        checks++; if ({Taken, Redirect} !== 2'b00) begin errors++; $display("FAIL blt_illegal got %b want 00", {Taken, Redirect}); end
        step();
        drive(1'b1, OP_BLE, 1'b1, 1'b1, 16'h0300);
        checks++; if ({Taken, Redirect} !== 2'b00) begin errors++; $display("FAIL bgt_illegal got %b want 00", {Taken, Redirect}); end
        step();
        drive(1'b1, OP_JMP, 1'b0, 1'b0, 16'h1234);
        checks++; if ({Taken, Redirect} !== 2'b11 || RedirectPC !== 16'h0300) begin
            errors++; $display("FAIL ble_illegal got %b/%h want 11/0300", {Taken, Redirect}, RedirectPC); end
        step();
        RedirectAck = 1'b1;
        step();
        RedirectAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if ({Flush, Taken, Redirect} !== 3'b100 || RedirectPC !== 16'h0300) begin
                errors++; $display("FAIL b2b_ignored%0d got %b/%h want 100/0300", i, {Flush, Taken, Redirect}, RedirectPC); end
            step();
        end
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if ({Ready, Redirect, Taken} !== 3'b100) begin errors++; $display("FAIL b2b_idle got %b want 100", {Ready, Redirect, Taken}); end
        step();
        checks++; if ({Ready, Redirect, Taken} !== 3'b100) begin errors++; $display("FAIL b2b_no_second got %b want 100", {Ready, Redirect, Taken}); end
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, OP_JMP, 1'b0, 1'b0, 16'h0ABC);
        step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        RedirectAck = 1'b1;
        step();
        RedirectAck = 1'b0;
        step();
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL mid_flush_setup got %b want 1", Flush); end
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        checks++; if ({Flush, Ready} !== 2'b01) begin errors++; $display("FAIL reset_in_flush got %b want 01", {Flush, Ready}); end
        drive(1'b1, OP_JMP, 1'b0, 1'b0, 16'h0DEF);
        step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if (Redirect !== 1'b1) begin errors++; $display("FAIL mid_req_setup got %b want 1", Redirect); end
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        checks++; if ({Redirect, Ready, Flush} !== 3'b010 || RedirectPC !== 16'h0) begin
            errors++; $display("FAIL reset_in_req got %b/%h want 010/0000", {Redirect, Ready, Flush}, RedirectPC); end
        step();
        checks++; if ({Redirect, Flush} !== 2'b00) begin errors++; $display("FAIL reset_no_persist got %b want 00", {Redirect, Flush}); end
    endtask

`ifdef BRANCH_RESOLVER_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_JMP, 1'b0, 1'b0, 16'h0010);
            step();
            drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
            RedirectAck = 1'b1;
            step();
            RedirectAck = 1'b0;
            step(); step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_BEQ, 1'b0, 1'b0, 16'h0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, OP_NOP, 1'b0, 1'b0, 16'h0);
            step();
        end
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if (TakenCount !== 16'd3) begin errors++; $display("FAIL stats_taken got %0d want 3", TakenCount); end
        checks++; if (NotTakenCount !== 16'd5) begin errors++; $display("FAIL stats_not_taken got %0d want 5", NotTakenCount); end
        drive(1'b1, OP_BNE, 1'b0, 1'b1, 16'h0);
        repeat (65530) step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if (NotTakenCount !== 16'hFFFF) begin errors++; $display("FAIL stats_reach_max got %h want ffff", NotTakenCount); end
        drive(1'b1, OP_BNE, 1'b0, 1'b1, 16'h0);
        repeat (3) step();
        drive(1'b0, OP_NOP, 1'b0, 1'b0, 16'h0);
        checks++; if (NotTakenCount !== 16'hFFFF || TakenCount !== 16'd3) begin
            errors++; $display("FAIL stats_saturate got %h/%0d want ffff/3", NotTakenCount, TakenCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_not_taken();
        test_blt_delayed_ack();
        test_immediate_ack_no_flush();
        test_illegal_flags_back_to_back();
        test_reset_mid_op();
`ifdef BRANCH_RESOLVER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
